// File: rtl/viz_pkg.sv
// Shared types and default sizing for the spectrum visualiser bar pipeline.
package viz_pkg;

  localparam int NUM_BARS_DEF   = 16;
  localparam int HEIGHT_W_DEF   = 9;
  localparam int ADDR_W_DEF     = 13;
  localparam int MAX_HEIGHT_DEF = 480;
  localparam int DECAY_STEP_DEF = 4;

  typedef logic [HEIGHT_W_DEF-1:0] height_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/peak_decay_unit.sv
// Combinational peak-hold cell: clamps a fresh sample to the display ceiling,
// lets the previously shown height fall by a fixed step (never below zero),
// and keeps whichever of the two is taller.
module peak_decay_unit #(
  parameter int HEIGHT_W   = viz_pkg::HEIGHT_W_DEF,
  parameter int MAX_HEIGHT = viz_pkg::MAX_HEIGHT_DEF,
  parameter int DECAY_STEP = viz_pkg::DECAY_STEP_DEF
) (
  input  logic [HEIGHT_W-1:0] sample,
  input  logic [HEIGHT_W-1:0] old_height,
  output logic [HEIGHT_W-1:0] new_height
);
  import viz_pkg::*;

  localparam logic [HEIGHT_W-1:0] MAX_H = HEIGHT_W'(MAX_HEIGHT);
  localparam logic [HEIGHT_W-1:0] STEP  = HEIGHT_W'(DECAY_STEP);

  logic [HEIGHT_W-1:0] clamped_s;
  logic [HEIGHT_W-1:0] decayed_s;

  // Clamp, saturating decay, then select the larger of the two.
  always_comb begin
    clamped_s  = {HEIGHT_W{1'b0}};
    decayed_s  = {HEIGHT_W{1'b0}};
    new_height = {HEIGHT_W{1'b0}};
    if (sample > MAX_H) begin
      clamped_s = MAX_H;
    end else begin
      clamped_s = sample;
    end
    if (old_height > STEP) begin
      decayed_s = old_height - STEP;
    end else begin
      decayed_s = {HEIGHT_W{1'b0}};
    end
    if (clamped_s > decayed_s) begin
      new_height = clamped_s;
    end else begin
      new_height = decayed_s;
    end
  end

endmodule

// File: rtl/height_update_sequencer.sv
// Once per frame, reads one 16-bin magnitude bank from the spectrum memory,
// folds it into the displayed heights with peak-hold/decay, and commits all
// bars in a single cycle followed by a one-cycle loaded pulse.
module height_update_sequencer #(
  parameter int NUM_BARS   = viz_pkg::NUM_BARS_DEF,
  parameter int HEIGHT_W   = viz_pkg::HEIGHT_W_DEF,
  parameter int ADDR_W     = viz_pkg::ADDR_W_DEF,
  parameter int MAX_HEIGHT = viz_pkg::MAX_HEIGHT_DEF,
  parameter int DECAY_STEP = viz_pkg::DECAY_STEP_DEF
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               frame_end,
  input  logic                               freeze,
  input  logic [9:0]                         sel,
  output logic                               mem_rd,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [HEIGHT_W-1:0]                mem_rdata,
  output logic [NUM_BARS-1:0][HEIGHT_W-1:0]  heights,
  output logic                               loaded,
  output logic                               busy,
  output logic [7:0]                         overrun_cnt
);
  import viz_pkg::*;

  localparam int              IDX_W    = $clog2(NUM_BARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);

  seq_state_t                        state_r, state_s;
  logic                              frame_end_q;
  logic [IDX_W-1:0]                  idx_r, idx_s;
  logic [IDX_W-1:0]                  cap_idx_r;
  logic [ADDR_W-1:0]                 base_r, base_s;
  logic [ADDR_W-1:0]                 addr_s;
  logic                              rd_s;
  logic                              rd_q_r;
  logic                              edge_s;
  logic                              start_s;
  logic [HEIGHT_W-1:0]               capture_s;
  logic [NUM_BARS-1:0][HEIGHT_W-1:0] shadow_r;
  logic                              sel_unused_s;

  // Only nine select bits form the bank base; the top bit is ignored.
  assign sel_unused_s = sel[9];

  assign edge_s  = frame_end & ~frame_end_q;
  assign start_s = edge_s & ~freeze & (state_r == IDLE);

  peak_decay_unit #(
    .HEIGHT_W   (HEIGHT_W),
    .MAX_HEIGHT (MAX_HEIGHT),
    .DECAY_STEP (DECAY_STEP)
  ) u_peak_decay (
    .sample     (mem_rdata),
    .old_height (heights[cap_idx_r]),
    .new_height (capture_s)
  );

  // Next-state, read index and next read strobe/address for the sequence.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    base_s  = base_r;
    addr_s  = {ADDR_W{1'b0}};
    rd_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = READ;
          idx_s   = {IDX_W{1'b0}};
          base_s  = ADDR_W'({sel[8:0], 4'b0000});
          addr_s  = ADDR_W'({sel[8:0], 4'b0000});
          rd_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (idx_r == LAST_IDX) begin
          state_s = DRAIN;
        end else begin
          idx_s  = idx_r + IDX_W'(1);
          addr_s = base_r + ADDR_W'(idx_r + IDX_W'(1));
          rd_s   = 1'b1;
        end
      end
      DRAIN:   state_s = COMMIT;
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state, edge detector and registered memory/status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      base_r      <= {ADDR_W{1'b0}};
      frame_end_q <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      busy        <= 1'b0;
      loaded      <= 1'b0;
      rd_q_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      base_r      <= base_s;
      frame_end_q <= frame_end;
      mem_rd      <= rd_s;
      mem_addr    <= addr_s;
      busy        <= (state_s != IDLE);
      loaded      <= (state_r == COMMIT);
      rd_q_r      <= mem_rd;
    end
  end

  // Capture each returned sample into the shadow bank, one bin per cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_r  <= {(NUM_BARS*HEIGHT_W){1'b0}};
      cap_idx_r <= {IDX_W{1'b0}};
    end else if (rd_q_r) begin
      shadow_r[cap_idx_r] <= capture_s;
      cap_idx_r           <= cap_idx_r + IDX_W'(1);
    end else if (state_r == IDLE) begin
      cap_idx_r <= {IDX_W{1'b0}};
    end else begin
      cap_idx_r <= cap_idx_r;
    end
  end

  // Commit the whole shadow bank to the visible heights in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      heights <= {(NUM_BARS*HEIGHT_W){1'b0}};
    end else if (state_r == COMMIT) begin
      heights <= shadow_r;
    end else begin
      heights <= heights;
    end
  end

  // Count frame ends that arrive while a sequence is still running.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_cnt <= 8'd0;
    end else if (edge_s && (state_r != IDLE) && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end else begin
      overrun_cnt <= overrun_cnt;
    end
  end

endmodule

// File: tb/tb_height_update_sequencer.sv
// Scoreboard bench for height_update_sequencer: stimulus pushes expected read
// addresses and committed height banks; a negedge monitor pops and compares.
module tb_height_update_sequencer;
  localparam int NB = 16;
  localparam int HW = 9;
  localparam int AW = 13;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   frame_end;
  logic                   freeze;
  logic [9:0]             sel;
  logic                   mem_rd;
  logic [AW-1:0]          mem_addr;
  logic [HW-1:0]          mem_rdata;
  logic [NB-1:0][HW-1:0]  heights;
  logic                   loaded;
  logic                   busy;
  logic [7:0]             overrun_cnt;

  typedef struct { logic [NB-1:0][HW-1:0] h; int due; } exp_t;
  typedef struct { int addr; int due; } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  exp_t mon_e;
  rd_t  mon_r;

  logic [HW-1:0]         mem [0:8191];
  logic [NB-1:0][HW-1:0] model_h;
  logic [9:0]            s;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int rd_count = 0;
  int exp_ovr = 0;
  int last_start = -100;
  int r0;

  always #5 clk = ~clk;

  height_update_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_end   (frame_end),
    .freeze      (freeze),
    .sel         (sel),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .heights     (heights),
    .loaded      (loaded),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  // Cycle counter and synchronous spectrum memory (data one cycle after read).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_h(input string name, input logic [NB-1:0][HW-1:0] act,
                         input logic [NB-1:0][HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare read strobes and loaded pulses against the queues.
  always @(negedge clk) begin
    if (mem_rd) begin
      rd_count <= rd_count + 1;
      if (rd_q.size() == 0) begin
        check_val("stray_mem_rd", 32'(mem_rd), 0);
      end else begin
        mon_r = rd_q.pop_front();
        check_val("mem_addr", 32'(mem_addr), mon_r.addr);
        check_val("mem_rd_cycle", cyc, mon_r.due);
      end
    end else if (rd_q.size() != 0 && cyc >= rd_q[0].due) begin
      check_val("missing_mem_rd", 32'(mem_rd), 1);
      void'(rd_q.pop_front());
    end
    if (loaded) begin
      if (exp_q.size() == 0) begin
        check_val("stray_loaded", 32'(loaded), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_h("heights", heights, mon_e.h);
        check_val("loaded_cycle", cyc, mon_e.due);
      end
    end else if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
      check_val("missing_loaded", 32'(loaded), 1);
      void'(exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference behaviour for one rising frame_end in the current cycle.
  task automatic edge_event(input logic [9:0] sv, input bit frz);
    int base, smp, dec, nh;
    exp_t e;
    rd_t  r;
    if (cyc - last_start <= 18) begin
      if (exp_ovr < 255) exp_ovr++;
    end else if (!frz) begin
      last_start = cyc;
      base = int'(sv[8:0]) * NB;
      for (int i = 0; i < NB; i++) begin
        r.addr = base + i;
        r.due  = cyc + 1 + i;
        rd_q.push_back(r);
        smp = int'(mem[base + i]);
        if (smp > 480) smp = 480;
        dec = int'(model_h[i]) - 4;
        if (dec < 0) dec = 0;
        nh = (smp > dec) ? smp : dec;
        model_h[i] = HW'(nh);
      end
      e.h   = model_h;
      e.due = cyc + 19;
      exp_q.push_back(e);
    end
  endtask

  task automatic fire(input logic [9:0] sv, input int hold, input bit frz);
    sel       = sv;
    freeze    = frz;
    frame_end = 1'b1;
    edge_event(sv, frz);
    tick(hold);
    frame_end = 1'b0;
    freeze    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (rd_q.size() == 0 && exp_q.size() == 0) break;
      tick(1);
    end
    check_val("wait_idle_timeout", rd_q.size() + exp_q.size(), 0);
    tick(2);
  endtask

  task automatic fill_bank(input int bank, input int value);
    for (int i = 0; i < NB; i++) mem[bank * NB + i] = HW'(value);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = '0;
    for (int i = 0; i < NB; i++) mem[16 + i] = HW'(10 * i);
    model_h   = '0;
    reset_n   = 1'b0;
    frame_end = 1'b0;
    freeze    = 1'b0;
    sel       = '0;
    tick(3);
    check_h("reset_heights", heights, '0);
    check_val("reset_loaded", 32'(loaded), 0);
    check_val("reset_mem_rd", 32'(mem_rd), 0);
    check_val("reset_mem_addr", 32'(mem_addr), 0);
    check_val("reset_busy", 32'(busy), 0);
    check_val("reset_overrun", 32'(overrun_cnt), 0);
    reset_n = 1'b1;
    tick(2);

    // Basic frame: bank 1 holds 10*i; check busy window and loaded timing.
    fire(10'd1, 1, 1'b0);
    check_val("busy_cycle1", 32'(busy), 1);
    tick(17);
    check_val("busy_cycle18", 32'(busy), 1);
    check_val("loaded_cycle18", 32'(loaded), 0);
    tick(1);
    check_val("busy_cycle19", 32'(busy), 0);
    check_val("loaded_cycle19", 32'(loaded), 1);
    wait_idle();
    check_val("height5_is_50", 32'(heights[5]), 50);

    // Decay: all-100 bank, then all-zero frames until every bar reaches zero.
    fill_bank(2, 100);
    fire(10'd2, 1, 1'b0);
    wait_idle();
    fire(10'd3, 1, 1'b0);
    wait_idle();
    check_val("decay_h0_96", 32'(heights[0]), 96);
    for (int k = 0; k < 40; k++) begin
      fire(10'd3, 1, 1'b0);
      wait_idle();
    end
    check_h("decay_floor_zero", heights, '0);

    // Clamp: full-scale samples limited to the display ceiling.
    fill_bank(4, 511);
    fire(10'd4, 1, 1'b0);
    wait_idle();
    check_val("clamp_h0_480", 32'(heights[0]), 480);

    // Long frame_end pulse starts exactly one sequence.
    fill_bank(5, 7);
    fire(10'd5, 40, 1'b0);
    wait_idle();

    // Freeze at the edge: no reads, no commit, counters unchanged.
    r0 = rd_count;
    fire(10'd1, 1, 1'b1);
    tick(25);
    check_val("freeze_no_reads", rd_count - r0, 0);
    check_h("freeze_heights", heights, model_h);
    check_val("freeze_overrun", 32'(overrun_cnt), exp_ovr);

    // Overrun: second edge at cycle 5 of a running sequence.
    fire(10'd1, 1, 1'b0);
    tick(4);
    fire(10'd9, 1, 1'b0);
    wait_idle();
    check_val("overrun_one", 32'(overrun_cnt), 1);

    // Randomised frames with fresh bank contents and occasional freeze.
    for (int k = 0; k < 20; k++) begin
      s = 10'($urandom);
      for (int i = 0; i < NB; i++) mem[int'(s[8:0]) * NB + i] = HW'($urandom);
      fire(s, $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
      sel = 10'($urandom);
      wait_idle();
      tick($urandom_range(0, 3));
    end

    // Saturation: nine extra edges per sequence until the counter tops out.
    for (int k = 0; k < 40; k++) begin
      fire(10'($urandom), 1, 1'b0);
      for (int j = 0; j < 9; j++) begin
        tick(1);
        fire(10'($urandom), 1, 1'b0);
      end
      wait_idle();
    end
    check_val("overrun_saturated", 32'(overrun_cnt), exp_ovr);
    check_val("overrun_is_255", 32'(overrun_cnt), 255);

    // Reset during READ: clears everything and suppresses the loaded pulse.
    fire(10'd1, 1, 1'b0);
    tick(9);
    reset_n = 1'b0;
    tick(1);
    rd_q.delete();
    exp_q.delete();
    model_h    = '0;
    exp_ovr    = 0;
    last_start = -100;
    check_val("midreset_mem_rd", 32'(mem_rd), 0);
    check_val("midreset_busy", 32'(busy), 0);
    check_val("midreset_loaded", 32'(loaded), 0);
    check_h("midreset_heights", heights, '0);
    check_val("midreset_overrun", 32'(overrun_cnt), 0);
    reset_n = 1'b1;
    tick(25);
    check_h("post_reset_heights", heights, '0);
    check_val("queues_drained", rd_q.size() + exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/height_update_sequencer.md
# height_update_sequencer

Frame-synchronous controller that refreshes the 16 displayed bar heights once per VGA frame. On the end-of-frame indication it reads one 16-bin magnitude bank from a synchronous spectrum memory, applies peak-hold with linear decay, and commits all heights atomically to the bar-rendering driver with a one-cycle `loaded` pulse. It sits between the spectrum memory and the VGA bar driver, replacing ad-hoc height loading.

## Interface

- `NUM_BARS`, 16, bars per frame; power of two
- `HEIGHT_W`, 9, height/sample width (unsigned)
- `ADDR_W`, 13, spectrum memory address width
- `MAX_HEIGHT`, 480, clamp ceiling for samples
- `DECAY_STEP`, 4, per-frame fall of a held peak

- `clk`  in  1  system clock (CLOCK_50 domain)
- `reset_n`  in  1  synchronous, active-low reset
- `frame_end`  in  1  level, high while last pixel (639,479) is active; may last several cycles
- `freeze`  in  1  when high, sampled frame ends are skipped (heights held)
- `sel`  in  10  bank select; base address = {sel[8:0], 4'b0000}
- `mem_rd`  out  1  read strobe to spectrum memory
- `mem_addr`  out  ADDR_W  read address
- `mem_rdata`  in  HEIGHT_W  read data, valid exactly 1 cycle after `mem_rd`
- `heights`  out  NUM_BARS x HEIGHT_W  committed bar heights
- `loaded`  out  1  one-cycle pulse, heights just changed
- `busy`  out  1  sequence in progress
- `overrun_cnt`  out  8  saturating count of frame ends dropped while busy

## Operation

- Start condition: rising edge of `frame_end` (registered copy `frame_end_q`), with `freeze`=0 in the same cycle. Long `frame_end` pulses start exactly one sequence.
- States: IDLE -> READ -> DRAIN -> COMMIT -> IDLE.
  - IDLE: outputs quiet; on start latch base from `sel`, idx=0, go READ.
  - READ: `mem_rd`=1, `mem_addr`=base+idx, idx increments; after idx=NUM_BARS-1 go DRAIN.
  - DRAIN: one cycle capturing the last datum; go COMMIT.
  - COMMIT: `heights` <= shadow; go IDLE; `loaded` asserted the following cycle.
- Capture: each returned sample s is clamped to MAX_HEIGHT; shadow[i] = max(s, old_i - DECAY_STEP), with subtraction saturating at 0; old_i = current `heights[i]`.
- Rising edge while busy, or while `freeze`=1: no sequence; busy-case increments `overrun_cnt` (saturates at 255); freeze-case does not count.
- `sel` changes after start have no effect until next sequence.
- Reset (any state): state IDLE, `heights` all 0, shadow 0, `loaded`=0, `mem_rd`=0, `mem_addr`=0, `busy`=0, `overrun_cnt`=0, `frame_end_q`=0.

## Timing

- Cycle 0: edge detected (frame_end=1, frame_end_q=0). Cycles 1..16: `mem_rd`=1, `mem_addr`=base+0..base+15.
- `mem_rdata` for address i sampled in cycle i+2 (cycles 2..17); cycle 17 is DRAIN.
- Cycle 18: COMMIT; `heights` updated at its closing edge. Cycle 19: `loaded`=1 for exactly one cycle.
- `busy`=1 cycles 1..18 inclusive. Start-to-loaded latency: 19 cycles, fixed.
- `heights` change only at COMMIT; never partially updated.
- Earliest next start: cycle 19 (new rising edge required).

## Structure

- Package `viz_pkg`: NUM_BARS, HEIGHT_W, MAX_HEIGHT defaults; `height_t` typedef; `seq_state_t` enum {IDLE, READ, DRAIN, COMMIT}.
- Sub-module `peak_decay_unit`: combinational clamp + saturating decay + max, one instance shared across bins.
- Top holds FSM, edge detector, index counter, shadow and committed arrays.

## Test plan

- Reset then single frame_end pulse, sel=1, memory holds bin i = 10*i at 16..31 -> addresses 16..31 on cycles 1..16, heights[i]=10*i, loaded high cycle 19 only.
- Decay: heights all 100, next bank all 0 -> heights 96; after 25 further all-zero frames -> 0, never wraps.
- Clamp: mem_rdata=511 -> height 480.
- frame_end held high 40 cycles -> exactly one sequence; second edge at cycle 5 of a sequence -> ignored, overrun_cnt=1; 300 such overruns -> 255.
- freeze=1 at edge -> no mem_rd, no loaded, heights unchanged, overrun_cnt unchanged.
- reset_n low in cycle 10 of READ -> next cycle IDLE, heights 0, mem_rd 0, no loaded pulse.
